// File: rtl/ctr163_sequencer.sv
// ctr163_sequencer: load/count/reload controller for a cascaded 74x163 counter chain
module ctr163_sequencer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         mode,
    input  logic [W-1:0] preset,
    input  logic         rco,
    output logic         ld_l,
    output logic         clr_l,
    output logic         enp,
    output logic         ent,
    output logic [W-1:0] d,
    output logic         busy,
    output logic         done,
    output logic [7:0]   tc_cnt
);
    typedef enum logic [2:0] {CLEAR, IDLE, LOAD, RUN, HOLD} state_t;
    state_t state, next;
    logic   mode_q;
    logic   tc;
    logic   latch;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= next;
    end

    // next state; stop outranks everything, start only honoured from IDLE/HOLD
    always_comb begin
        next = state;
        if (stop) next = CLEAR;
        else begin
            case (state)
                CLEAR:      next = IDLE;
                IDLE, HOLD: next = start ? LOAD : state;
                LOAD:       next = RUN;
                RUN:        next = (tc && !mode_q) ? HOLD : RUN;
                default:    next = CLEAR;
            endcase
        end
    end

    // chain control that must react within the cycle: load and count-enable P
    always_comb begin
        tc    = state == RUN && rco && !pause;
        latch = start && !stop && (state == IDLE || state == HOLD);
        ld_l  = !(state == LOAD || (tc && mode_q));
        enp   = state == RUN && !pause && !(tc && !mode_q);
    end

    // registered outputs follow the state being entered so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_l  <= 1'b0;
            ent    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            mode_q <= 1'b0;
            tc_cnt <= '0;
        end else begin
            clr_l  <= next != CLEAR;
            ent    <= next == LOAD || next == RUN || next == HOLD;
            busy   <= next == LOAD || next == RUN;
            done   <= tc && !stop;
            d      <= latch ? preset : d;
            mode_q <= latch ? mode : mode_q;
            tc_cnt <= latch ? 8'd0 : (tc && !stop) ? tc_cnt + 8'd1 : tc_cnt;
        end
    end
endmodule

// File: tb/tb_ctr163_sequencer.sv
// tb_ctr163_sequencer: directed bench driving the sequencer against a behavioural 74x163 chain
module tb_ctr163_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] preset = 8'h00;
    logic       rco;
    logic       ld_l, clr_l, enp, ent, busy, done;
    logic [7:0] d, tc_cnt;
    logic [7:0] q;

    int vectors = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    ctr163_sequencer #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .preset(preset), .rco(rco), .ld_l(ld_l), .clr_l(clr_l),
        .enp(enp), .ent(ent), .d(d), .busy(busy), .done(done), .tc_cnt(tc_cnt)
    );

    always #5 clk = ~clk;

    // two cascaded 74x163 stages: sync clear > sync load > count on ENP&ENT
    always @(posedge clk) begin
        if (!clr_l)            q <= 8'h00;
        else if (!ld_l)        q <= d;
        else if (enp && ent)   q <= q + 8'h01;
    end
    assign rco = ent && (q == 8'hFF);

    task automatic push(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string p);
        push({p, "_clr_l"}, 0);  chk(clr_l);
        push({p, "_ld_l"}, 1);   chk(ld_l);
        push({p, "_enp"}, 0);    chk(enp);
        push({p, "_ent"}, 0);    chk(ent);
        push({p, "_d"}, 0);      chk(d);
        push({p, "_busy"}, 0);   chk(busy);
        push({p, "_done"}, 0);   chk(done);
        push({p, "_tc_cnt"}, 0); chk(tc_cnt);
    endtask

    initial begin
        int ndone;
        // power-on reset
        step();
        step();
        reset_vals("por");
        rst = 1'b0;
        step();
        push("por_idle_clr_l", 1); chk(clr_l);
        push("por_q", 0);          chk(q);

        // one-shot FA
        preset = 8'hFA; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        push("os_load_ld_l", 0);  chk(ld_l);
        push("os_load_busy", 1);  chk(busy);
        push("os_load_d", 8'hFA); chk(d);
        push("os_load_enp", 0);   chk(enp);
        step();
        for (int i = 0; i < 6; i++) begin
            push("os_q", 8'hFA + i);     chk(q);
            push("os_done", 0);          chk(done);
            push("os_ld_l", 1);          chk(ld_l);
            push("os_enp", i == 5 ? 0 : 1); chk(enp);
            step();
        end
        push("os_done_pulse", 1); chk(done);
        push("os_busy_fall", 0);  chk(busy);
        push("os_tc_cnt", 1);     chk(tc_cnt);
        push("os_q_hold", 8'hFF); chk(q);
        step();
        push("os_done_single", 0); chk(done);
        push("os_q_hold2", 8'hFF); chk(q);
        push("os_tc_cnt2", 1);     chk(tc_cnt);

        // periodic FC from HOLD
        preset = 8'hFC; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        push("per_tc_cnt_clr", 0); chk(tc_cnt);
        step();
        for (int i = 0; i < 12; i++) begin
            push("per_q", 8'hFC + (i % 4));             chk(q);
            push("per_ld_l", (i % 4 == 3) ? 0 : 1);     chk(ld_l);
            push("per_done", (i % 4 == 0 && i > 0) ? 1 : 0); chk(done);
            step();
        end
        push("per_done_last", 1); chk(done);
        push("per_tc_cnt", 3);    chk(tc_cnt);

        // stop from RUN
        stop = 1'b1;
        step();
        stop = 1'b0;
        push("stop_clr_l", 0); chk(clr_l);
        push("stop_done", 0);  chk(done);
        push("stop_busy", 0);  chk(busy);
        step();
        push("stop_q", 0);       chk(q);
        push("stop_idle_clr", 1); chk(clr_l);

        // pause, periodic F0
        preset = 8'hF0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        repeat (8) step();
        push("pz_q_at_9", 8'hF8); chk(q);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            push("pz_q_hold", 8'hF8); chk(q);
            push("pz_enp", 0);        chk(enp);
            step();
        end
        pause = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push("pz_no_early_tc", 1); chk(ld_l);
            step();
        end
        push("pz_tc_cycle21_ld_l", 0); chk(ld_l);
        push("pz_tc_cycle21_q", 8'hFF); chk(q);
        step();
        push("pz_done", 1);     chk(done);
        push("pz_reload", 8'hF0); chk(q);
        repeat (15) step();
        push("pzff_q", 8'hFF); chk(q);
        pause = 1'b1;
        #1;
        push("pzff_ld_l", 1); chk(ld_l);
        push("pzff_enp", 0);  chk(enp);
        for (int i = 0; i < 3; i++) begin
            step();
            push("pzff_done", 0);   chk(done);
            push("pzff_q", 8'hFF);  chk(q);
        end
        pause = 1'b0;
        #1;
        push("pzff_release_ld_l", 0); chk(ld_l);
        step();
        push("pzff_release_done", 1); chk(done);
        push("pzff_release_q", 8'hF0); chk(q);

        // stop during LOAD
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        preset = 8'h55; start = 1'b1;
        step();
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        push("ldstop_clr_l", 0); chk(clr_l);
        push("ldstop_busy", 0);  chk(busy);
        push("ldstop_done", 0);  chk(done);
        step();
        push("ldstop_q", 0);     chk(q);
        push("ldstop_done2", 0); chk(done);
        push("ldstop_d", 8'h55); chk(d);

        // start+stop collision in IDLE
        preset = 8'hAA; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        push("coll_clr_l", 0);  chk(clr_l);
        push("coll_d", 8'h55);  chk(d);
        push("coll_busy", 0);   chk(busy);
        step();
        push("coll_idle_clr", 1); chk(clr_l);
        push("coll_idle_busy", 0); chk(busy);

        // periodic FF: TC every cycle, counter wraps, mid-run START ignored
        preset = 8'hFF; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        push("ff_q", 8'hFF);  chk(q);
        push("ff_ld_l", 0);   chk(ld_l);
        ndone = 0;
        for (int i = 2; i <= 257; i++) begin
            step();
            if (done === 1'b1) ndone++;
            if (i == 100) begin
                start = 1'b1;
                preset = 8'h00;
            end else start = 1'b0;
            if (i == 256) begin
                push("ff_tc_cnt_255", 8'd255); chk(tc_cnt);
            end
        end
        push("ff_tc_cnt_wrap", 0); chk(tc_cnt);
        push("ff_done_count", 256); chk(ndone);
        push("ff_d_kept", 8'hFF);   chk(d);
        push("ff_busy", 1);         chk(busy);

        // periodic 00: 256-cycle period
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        preset = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        step();
        push("p00_q1", 0); chk(q);
        repeat (255) step();
        push("p00_q256", 8'hFF); chk(q);
        push("p00_tc1", 0);      chk(ld_l);
        repeat (256) step();
        push("p00_tc2", 0);       chk(ld_l);
        push("p00_tc_cnt1", 1);   chk(tc_cnt);
        step();
        push("p00_done", 1);      chk(done);
        push("p00_tc_cnt2", 2);   chk(tc_cnt);

        // asynchronous reset mid-RUN
        step();
        rst = 1'b1;
        #1;
        reset_vals("async");
        step();
        rst = 1'b0;
        push("rel_clear", 0); chk(clr_l);
        step();
        push("rel_idle_clr", 1); chk(clr_l);
        push("rel_q", 0);        chk(q);
        push("rel_busy", 0);     chk(busy);
        push("rel_done", 0);     chk(done);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
